// File: rtl/ks_control_fsm_mc_if.sv
// Control/flag bundle between the K&S multicycle control FSM and its datapath.
interface ks_control_fsm_mc_if;
    logic       zero_op;
    logic       neg_op;
    logic       unsigned_overflow;
    logic       signed_overflow;
    logic       branch;
    logic       pc_enable;
    logic       ir_enable;
    logic       write_reg_enable;
    logic       addr_sel;
    logic       c_sel;
    logic [1:0] operation;
    logic       flags_reg_enable;
    logic       ram_write_enable;
    logic       halt;
    logic       illegal;

    modport master (
        input  zero_op, neg_op, unsigned_overflow, signed_overflow,
        output branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel,
               operation, flags_reg_enable, ram_write_enable, halt, illegal
    );

    modport slave (
        output zero_op, neg_op, unsigned_overflow, signed_overflow,
        input  branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel,
               operation, flags_reg_enable, ram_write_enable, halt, illegal
    );
endinterface

// File: rtl/ks_control_fsm_mc.sv
// K&S multicycle control FSM with memory wait states and illegal-decode handling.
// Optional retired-instruction counter enabled by macro KS_CU_PERF_CNT_EN.
package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
        I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
    } decoded_instruction_type;
endpackage

module ks_control_fsm_mc
    import k_and_s_pkg::*;
#(
    parameter int unsigned MEM_LAT      = 0,
    parameter bit          OVF_SIGNED   = 1'b0,
    parameter bit          ILLEGAL_HALT = 1'b1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    ks_control_fsm_mc_if.master     ctl,
    output logic [CNT_W-1:0]        instr_count
);

    localparam int unsigned         WAIT_W    = (MEM_LAT == 0) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(MEM_LAT);

    typedef enum logic [3:0] {
        S_FETCH, S_IR_LOAD, S_DECODE, S_ALU, S_MOVE, S_BR_EVAL,
        S_LOAD_ADDR, S_LOAD_WB, S_STORE_ADDR, S_STORE_WR, S_HALT
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    function automatic logic [1:0] alu_op(input decoded_instruction_type d);
        case (d)
            I_SUB:        alu_op = 2'b01;
            I_AND:        alu_op = 2'b10;
            I_OR, I_MOVE: alu_op = 2'b11;
            default:      alu_op = 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        state    <= S_IR_LOAD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_IR_LOAD: state <= S_DECODE;
                S_DECODE: begin
                    case (decoded_instruction)
                        I_ADD, I_SUB, I_AND, I_OR:             state <= S_ALU;
                        I_MOVE:                                state <= S_MOVE;
                        I_LOAD:                                state <= S_LOAD_ADDR;
                        I_STORE:                               state <= S_STORE_ADDR;
                        I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
                        I_BNNEG, I_BOV, I_BNOV:                state <= S_BR_EVAL;
                        I_HALT:                                state <= S_HALT;
                        default: state <= ILLEGAL_HALT ? S_HALT : S_FETCH;
                    endcase
                end
                S_LOAD_ADDR: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        state    <= S_LOAD_WB;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_STORE_ADDR: state <= S_STORE_WR;
                S_ALU, S_MOVE, S_BR_EVAL, S_LOAD_WB, S_STORE_WR: state <= S_FETCH;
                S_HALT:       state <= S_HALT;
                default:      state <= S_FETCH;
            endcase
        end
    end

    logic ovf;
    logic take;
    assign ovf = OVF_SIGNED ? ctl.signed_overflow : ctl.unsigned_overflow;

    always_comb begin
        case (decoded_instruction)
            I_BRANCH: take = 1'b1;
            I_BZERO:  take = ctl.zero_op;
            I_BNZERO: take = !ctl.zero_op;
            I_BNEG:   take = ctl.neg_op;
            I_BNNEG:  take = !ctl.neg_op;
            I_BOV:    take = ovf;
            I_BNOV:   take = !ovf;
            default:  take = 1'b0;
        endcase
    end

    always_comb begin
        ctl.branch           = 1'b0;
        ctl.pc_enable        = 1'b0;
        ctl.ir_enable        = 1'b0;
        ctl.write_reg_enable = 1'b0;
        ctl.addr_sel         = 1'b0;
        ctl.c_sel            = 1'b0;
        ctl.operation        = 2'b00;
        ctl.flags_reg_enable = 1'b0;
        ctl.ram_write_enable = 1'b0;
        ctl.halt             = 1'b0;
        ctl.illegal          = 1'b0;
        case (state)
            S_IR_LOAD: begin
                ctl.ir_enable = 1'b1;
                ctl.pc_enable = 1'b1;
            end
            S_DECODE: begin
                ctl.operation = alu_op(decoded_instruction);
                case (decoded_instruction)
                    I_LOAD, I_STORE: ctl.addr_sel = 1'b1;
                    I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_BRANCH, I_BZERO,
                    I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT: ;
                    default: ctl.illegal = 1'b1;
                endcase
            end
            S_ALU: begin
                ctl.write_reg_enable = 1'b1;
                ctl.flags_reg_enable = 1'b1;
                ctl.operation        = alu_op(decoded_instruction);
            end
            S_MOVE: begin
                ctl.write_reg_enable = 1'b1;
                ctl.operation        = 2'b11;
            end
            S_BR_EVAL: begin
                ctl.branch    = take;
                ctl.pc_enable = take;
            end
            S_LOAD_ADDR: begin
                ctl.addr_sel = 1'b1;
                ctl.c_sel    = 1'b1;
            end
            S_LOAD_WB: begin
                ctl.addr_sel         = 1'b1;
                ctl.c_sel            = 1'b1;
                ctl.write_reg_enable = 1'b1;
            end
            S_STORE_ADDR: ctl.addr_sel = 1'b1;
            S_STORE_WR: begin
                ctl.addr_sel         = 1'b1;
                ctl.ram_write_enable = 1'b1;
            end
            S_HALT:  ctl.halt = 1'b1;
            default: ;
        endcase
    end

`ifdef KS_CU_PERF_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] count_q;

    // An illegal skip re-enters FETCH from DECODE, so it is never counted here.
    always_comb begin
        retire = 1'b0;
        case (state)
            S_ALU, S_MOVE, S_BR_EVAL, S_LOAD_WB, S_STORE_WR: retire = 1'b1;
            S_DECODE: retire = (decoded_instruction == I_HALT);
            default:  retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (retire && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign instr_count = count_q;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_ks_control_fsm_mc.sv
// Directed self-checking bench for ks_control_fsm_mc: two parameter sets run side by side.
module tb_ks_control_fsm_mc;
    import k_and_s_pkg::*;

`ifdef KS_CU_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_a, rst_b;
    decoded_instruction_type dec_a, dec_b;
    logic [15:0]             cnt_a, cnt_b;
    logic [31:0]             ctl_a, ctl_b;

    ks_control_fsm_mc_if ifa ();
    ks_control_fsm_mc_if ifb ();

    ks_control_fsm_mc #(.MEM_LAT(0), .OVF_SIGNED(1'b0), .ILLEGAL_HALT(1'b0), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_a), .decoded_instruction(dec_a), .ctl(ifa.master), .instr_count(cnt_a)
    );
    ks_control_fsm_mc #(.MEM_LAT(2), .OVF_SIGNED(1'b1), .ILLEGAL_HALT(1'b1), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_b), .decoded_instruction(dec_b), .ctl(ifb.master), .instr_count(cnt_b)
    );

    // {branch, pc_en, ir_en, wr_reg, addr_sel, c_sel, op[1:0], flags_en, ram_we, halt, illegal}
    assign ctl_a = {20'b0, ifa.branch, ifa.pc_enable, ifa.ir_enable, ifa.write_reg_enable,
                    ifa.addr_sel, ifa.c_sel, ifa.operation, ifa.flags_reg_enable,
                    ifa.ram_write_enable, ifa.halt, ifa.illegal};
    assign ctl_b = {20'b0, ifb.branch, ifb.pc_enable, ifb.ir_enable, ifb.write_reg_enable,
                    ifb.addr_sel, ifb.c_sel, ifb.operation, ifb.flags_reg_enable,
                    ifb.ram_write_enable, ifb.halt, ifb.illegal};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        return (PERF != 0) ? 32'(n) : 32'd0;
    endfunction

    task automatic nx(input string tag, input bit use_b, input logic [31:0] exp);
        @(negedge clk);
        #1;
        check(tag, use_b ? ctl_b : ctl_a, exp);
    endtask

    // Starting in FETCH on dut_a (MEM_LAT=0), run one 4-cycle instruction back to FETCH.
    task automatic seq_a(input string tag, input decoded_instruction_type ins,
                         input logic [31:0] dec_exp, input logic [31:0] exe_exp);
        dec_a = ins;
        nx({tag, "_ir"},  1'b0, 32'h600);
        nx({tag, "_dec"}, 1'b0, dec_exp);
        nx({tag, "_exe"}, 1'b0, exe_exp);
        nx({tag, "_fet"}, 1'b0, 32'h000);
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        dec_a = I_NOP;
        dec_b = I_NOP;
        {ifa.zero_op, ifa.neg_op, ifa.unsigned_overflow, ifa.signed_overflow} = 4'b0;
        {ifb.zero_op, ifb.neg_op, ifb.unsigned_overflow, ifb.signed_overflow} = 4'b0;
        @(negedge clk);
        #1;
        check("rst_a_ctl", ctl_a, 32'h0);
        check("rst_a_cnt", {16'b0, cnt_a}, 32'h0);
        check("rst_b_ctl", ctl_b, 32'h0);
        check("rst_b_cnt", {16'b0, cnt_b}, 32'h0);

        // dut_a: MEM_LAT=0, unsigned overflow, illegal skips
        dec_a = I_ADD;
        rst_a = 1'b1;
        check("add_fetch", ctl_a, 32'h000);
        nx("add_ir",  1'b0, 32'h600);
        nx("add_dec", 1'b0, 32'h000);
        nx("add_alu", 1'b0, 32'h108);
        nx("add_fet", 1'b0, 32'h000);
        check("add_cnt", {16'b0, cnt_a}, exp_cnt(1));
        seq_a("sub",  I_SUB,  32'h010, 32'h118);
        seq_a("and",  I_AND,  32'h020, 32'h128);
        seq_a("move", I_MOVE, 32'h030, 32'h130);
        ifa.neg_op = 1'b0;
        seq_a("bnneg_t", I_BNNEG, 32'h000, 32'hC00);
        ifa.neg_op = 1'b1;
        seq_a("bnneg_n", I_BNNEG, 32'h000, 32'h000);
        ifa.signed_overflow   = 1'b1;
        ifa.unsigned_overflow = 1'b0;
        seq_a("bov_uns", I_BOV, 32'h000, 32'h000);
        ifa.zero_op = 1'b1;
        seq_a("bzero_t", I_BZERO, 32'h000, 32'hC00);
        check("br_cnt", {16'b0, cnt_a}, exp_cnt(8));

        dec_a = I_NOP;
        nx("ill_ir",   1'b0, 32'h600);
        nx("ill_dec",  1'b0, 32'h001);
        nx("ill_fet",  1'b0, 32'h000);
        nx("ill_ir2",  1'b0, 32'h600);
        nx("ill_dec2", 1'b0, 32'h001);
        nx("ill_fet2", 1'b0, 32'h000);
        check("ill_cnt", {16'b0, cnt_a}, exp_cnt(8));

        dec_a = I_STORE;
        nx("st_ir",  1'b0, 32'h600);
        nx("st_dec", 1'b0, 32'h080);
        nx("st_sa",  1'b0, 32'h080);
        rst_a = 1'b0;
        #1;
        check("st_rst_ctl", ctl_a, 32'h0);
        check("st_rst_cnt", {16'b0, cnt_a}, 32'h0);
        nx("st_rst_h1", 1'b0, 32'h0);
        nx("st_rst_h2", 1'b0, 32'h0);
        rst_a = 1'b1;
        check("st2_fetch", ctl_a, 32'h000);
        nx("st2_ir",  1'b0, 32'h600);
        nx("st2_dec", 1'b0, 32'h080);
        nx("st2_sa",  1'b0, 32'h080);
        nx("st2_sw",  1'b0, 32'h084);
        nx("st2_fet", 1'b0, 32'h000);
        check("st2_cnt", {16'b0, cnt_a}, exp_cnt(1));

        dec_a = I_HALT;
        nx("hlt_ir",  1'b0, 32'h600);
        nx("hlt_dec", 1'b0, 32'h000);
        nx("hlt_h1",  1'b0, 32'h002);
        nx("hlt_h2",  1'b0, 32'h002);
        check("hlt_cnt", {16'b0, cnt_a}, exp_cnt(2));

        // dut_b: MEM_LAT=2, signed overflow, illegal halts
        dec_b = I_LOAD;
        rst_b = 1'b1;
        check("ld_f1", ctl_b, 32'h000);
        nx("ld_f2",  1'b1, 32'h000);
        nx("ld_f3",  1'b1, 32'h000);
        nx("ld_ir",  1'b1, 32'h600);
        nx("ld_dec", 1'b1, 32'h080);
        for (int i = 0; i < 3; i++) nx("ld_la", 1'b1, 32'h0C0);
        nx("ld_wb",  1'b1, 32'h1C0);
        nx("ld_fet", 1'b1, 32'h000);
        check("ld_cnt", {16'b0, cnt_b}, exp_cnt(1));

        dec_b = I_BOV;
        ifb.signed_overflow   = 1'b1;
        ifb.unsigned_overflow = 1'b0;
        nx("bov_f2",  1'b1, 32'h000);
        nx("bov_f3",  1'b1, 32'h000);
        nx("bov_ir",  1'b1, 32'h600);
        nx("bov_dec", 1'b1, 32'h000);
        nx("bov_br",  1'b1, 32'hC00);
        nx("bov_fet", 1'b1, 32'h000);
        check("bov_cnt", {16'b0, cnt_b}, exp_cnt(2));

        dec_b = I_NOP;
        nx("ilh_f2",  1'b1, 32'h000);
        nx("ilh_f3",  1'b1, 32'h000);
        nx("ilh_ir",  1'b1, 32'h600);
        nx("ilh_dec", 1'b1, 32'h001);
        for (int i = 0; i < 20; i++) nx("ilh_halt", 1'b1, 32'h002);
        check("ilh_cnt", {16'b0, cnt_b}, exp_cnt(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
